wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DW, default 32, data width of the register file and write-back data.
REQ-002 Parameter NREG, default 32, number of architectural registers; index width is clog2(NREG).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  4  phase bus shared with the other stages; start[3] is the write-back phase.
REQ-006 op  in  6  opcode of the instruction in flight (same encoding as the memory stage).
REQ-007 rd  in  5  destination register index.
REQ-008 wb_data_i  in  DW  result delivered by the memory stage.
REQ-009 rs_addr, rt_addr  in  5 each  read-port indices.
REQ-010 rs_data, rt_data  out  DW each  combinational read data.
REQ-011 wb_done  out  1  one-cycle pulse when an instruction retires.
REQ-012 instret  out  32  count of retired instructions.
REQ-013 phase_err  out  1  sticky flag for a write-back phase that arrived while busy.

Function
REQ-014 The block SHALL register start[3] through a two-flop synchronizer, then edge-detect it; only a synchronized rising edge starts a write-back.
REQ-015 FSM states SHALL be IDLE, LATCH, COMMIT and DONE.
REQ-016 IDLE -> LATCH on a detected edge; LATCH captures op, rd and wb_data_i into holding registers.
REQ-017 LATCH -> COMMIT unconditionally, one cycle later.
REQ-018 COMMIT performs the register write, if any, and moves to DONE.
REQ-019 DONE asserts wb_done for exactly one cycle, increments instret, and returns to IDLE.
REQ-020 Latency SHALL be 3 cycles from the synchronized edge to wb_done, plus 2 cycles of synchronizer delay.
REQ-021 Ops 000000–000101 (ALU), 010001 (LW), 100000 and 100001 (link) SHALL write the held data to register rd.
REQ-022 Op 010000 (SW) and every other opcode SHALL perform no write but still retire: wb_done pulses and instret increments.
REQ-023 Register 0 SHALL always read zero; writes to it are discarded.
REQ-024 If rd >= NREG, the write SHALL be discarded.
REQ-025 Read ports SHALL bypass: in the COMMIT cycle, a read whose address matches the written register returns the new data.
REQ-026 A detected edge in any state other than IDLE SHALL be ignored and SHALL set phase_err; phase_err clears only on reset.
REQ-027 instret SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Inputs SHALL be sampled only in LATCH; changes to them at any other time have no effect.

Reset
REQ-029 Reset SHALL set: FSM to IDLE, synchronizer flops to 0, wb_done 0, instret 0, phase_err 0, holding registers 0, and all registers to 0.
REQ-030 Reset asserted mid-operation SHALL abort the instruction: no register write, no wb_done, no count.
REQ-031 After reset release, a start[3] already high SHALL NOT be treated as an edge.

Structure
REQ-032 Opcode constants (ALU group, SW, LW, link ops) and the FSM state encoding SHALL live in a shared package, cpu_pkg, that is also used by the memory stage.
REQ-033 The register array with bypass logic SHALL be a sub-module, wb_regfile, instantiated once; wb_stage holds the synchronizer, FSM and counter.

Verification
REQ-034 Reset, then pulse start[3] with op=000000, rd=5, data=0x1234 → rs_addr=5 reads 0x1234 after wb_done; instret=1.
REQ-035 op=010000, rd=7, data=0xFFFF → r7 stays 0, wb_done pulses, instret increments.
REQ-036 op=010001, rd=0, data=0xDEAD → r0 reads 0.
REQ-037 rs_addr=9 held while a write of 0xA5A5 to r9 commits → rs_data=0xA5A5 in the COMMIT cycle.
REQ-038 Second start[3] edge one cycle after the first → only one retire, phase_err=1.
REQ-039 rst_n low during COMMIT with rd=3 → r3=0, no wb_done; preload instret to 0xFFFFFFFF, retire once → instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, register index width and the
// write-back FSM state encoding used by the pipeline stages.
package cpu_pkg;

  localparam int RIDX_W = 5;

  localparam logic [5:0] OP_ALU_FIRST = 6'b000000;
  localparam logic [5:0] OP_ALU_LAST  = 6'b000101;
  localparam logic [5:0] OP_SW        = 6'b010000;
  localparam logic [5:0] OP_LW        = 6'b010001;
  localparam logic [5:0] OP_LINK      = 6'b100000;
  localparam logic [5:0] OP_LINK_R    = 6'b100001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } wb_state_e;

  // True for opcodes whose result lands in the destination register.
  function automatic logic op_writes_rd(input logic [5:0] op);
    return ((op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST)) ||
           (op == OP_LW) || (op == OP_LINK) || (op == OP_LINK_R);
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports
// that forward the data being written in the same cycle. r0 is hardwired to zero.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [RIDX_W-1:0] rs_addr_i,
  input  logic [RIDX_W-1:0] rt_addr_i,
  output logic [DW-1:0]     rs_data_o,
  output logic [DW-1:0]     rt_data_o
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DW-1:0] regs_q [NREG];
  logic          wr_ok;
  logic          rs_ok;
  logic          rt_ok;

  // Writes to r0 or to an index beyond the array are dropped here.
  assign wr_ok = we_i && (waddr_i != '0) && (32'(waddr_i) < NREG);
  assign rs_ok = (rs_addr_i != '0) && (32'(rs_addr_i) < NREG);
  assign rt_ok = (rt_addr_i != '0) && (32'(rt_addr_i) < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rs_data_o = '0;
    if (rs_ok) begin
      rs_data_o = (wr_ok && (rs_addr_i == waddr_i)) ? wdata_i : regs_q[rs_addr_i[AW-1:0]];
    end
  end

  always_comb begin
    rt_data_o = '0;
    if (rt_ok) begin
      rt_data_o = (wr_ok && (rt_addr_i == waddr_i)) ? wdata_i : regs_q[rt_addr_i[AW-1:0]];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: synchronizes the write-back phase strobe, sequences
// LATCH/COMMIT/DONE, retires into the register file and counts retirements.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        start,
  input  logic [5:0]        op,
  input  logic [RIDX_W-1:0] rd,
  input  logic [DW-1:0]     wb_data_i,
  input  logic [RIDX_W-1:0] rs_addr,
  input  logic [RIDX_W-1:0] rt_addr,
  output logic [DW-1:0]     rs_data,
  output logic [DW-1:0]     rt_data,
  output logic              wb_done,
  output logic [31:0]       instret,
  output logic              phase_err
);

  logic              sync1_q, sync2_q, sync3_q;
  logic [1:0]        warm_q, warm_d;
  wb_state_e         state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic [DW-1:0]     data_q, data_d;
  logic              wb_done_q, wb_done_d;
  logic [31:0]       instret_q, instret_d;
  logic              phase_err_q, phase_err_d;
  logic              edge_det;
  logic              rf_we;
  logic              unused_start;

  // Only start[3] belongs to this stage.
  assign unused_start = ^start[2:0];

  // warm_q holds off edge detection until the history flop carries a real
  // sample, so a strobe already high at reset release is not an edge.
  assign edge_det = sync2_q && !sync3_q && (warm_q == 2'd3);

  always_comb begin
    warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    data_d      = data_q;
    wb_done_d   = 1'b0;
    instret_d   = instret_q;
    phase_err_d = phase_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (edge_det) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        op_d    = op;
        rd_d    = rd;
        data_d  = wb_data_i;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d   = ST_DONE;
        wb_done_d = 1'b1;
        instret_d = instret_q + 32'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (edge_det && (state_q != ST_IDLE)) phase_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      warm_q      <= 2'd0;
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      wb_done_q   <= 1'b0;
      instret_q   <= '0;
      phase_err_q <= 1'b0;
    end else begin
      sync1_q     <= start[3];
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      warm_q      <= warm_d;
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      wb_done_q   <= wb_done_d;
      instret_q   <= instret_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign rf_we = (state_q == ST_COMMIT) && op_writes_rd(op_q);

  wb_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd_q),
    .wdata_i   (data_q),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data)
  );

  assign wb_done   = wb_done_q;
  assign instret   = instret_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// retirements checked against a register-file/counter model.
module tb_wb_stage;

  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    start = '0;
  logic [5:0]    op = '0;
  logic [4:0]    rd = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic [4:0]    rs_addr = '0;
  logic [4:0]    rt_addr = '0;
  logic [DW-1:0] rs_data, rt_data;
  logic          wb_done;
  logic [31:0]   instret;
  logic          phase_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_regs [32];
  logic [31:0]   model_instret;
  logic          model_perr;

  wb_stage #(.DW(DW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rd        (rd),
    .wb_data_i (wb_data_i),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wb_done   (wb_done),
    .instret   (instret),
    .phase_err (phase_err)
  );

  always #5 clk = ~clk;

  // Opcodes that write rd: ALU 0..5, LW 17, link 32/33.
  function automatic bit ref_writes(input logic [5:0] o);
    return (o <= 6'd5) || (o == 6'd17) || (o == 6'd32) || (o == 6'd33);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREG) return '0;
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_instret = '0;
    model_perr    = 1'b0;
  endtask

  task automatic model_retire(input logic [5:0] o, input logic [4:0] r, input logic [DW-1:0] d);
    if (ref_writes(o) && r != 5'd0 && int'(r) < NREG) model_regs[r] = d;
    model_instret = model_instret + 32'd1;
  endtask

  function automatic logic [DW-1:0] model_bypass(input logic [5:0] o, input logic [4:0] r,
                                                 input logic [DW-1:0] d, input logic [4:0] a);
    if (ref_writes(o) && r != 5'd0 && int'(r) < NREG && a == r) return d;
    return model_read(a);
  endfunction

  // Drives one write-back phase pulse; inputs are scrambled right after the
  // LATCH cycle. Returns the cycle count to wb_done (0 = timeout), rs_data in
  // the COMMIT cycle and wb_done one cycle after the pulse.
  task automatic run_instr(input logic [5:0] i_op, input logic [4:0] i_rd,
                           input logic [DW-1:0] i_data, input logic [4:0] probe,
                           output int lat, output logic [DW-1:0] commit_rs,
                           output logic done_after);
    @(negedge clk);
    op        = i_op;
    rd        = i_rd;
    wb_data_i = i_data;
    rs_addr   = probe;
    start     = {1'b1, 3'($urandom)};
    lat        = 0;
    commit_rs  = '0;
    done_after = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start[3] = 1'b0;
      if (n == 4) begin
        commit_rs = rs_data;
        op        = 6'($urandom);
        rd        = 5'($urandom);
        wb_data_i = DW'($urandom);
      end
      if (wb_done) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    done_after = wb_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wb_done !== 1'b0) begin n_fail++; $display("FAIL reset_wb_done got=%b exp=0", wb_done); end
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got=%h exp=0", instret); end
    n_checks++; if (phase_err !== 1'b0) begin n_fail++; $display("FAIL reset_phase_err got=%b exp=0", phase_err); end
    n_checks++; if (wb_done !== 1'b0) begin n_fail++; $display("FAIL idle_wb_done got=%b exp=0", wb_done); end
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      n_checks++; if (rs_data !== '0) begin n_fail++; $display("FAIL reset_rs r%0d got=%h exp=0", i, rs_data); end
      n_checks++; if (rt_data !== '0) begin n_fail++; $display("FAIL reset_rt r%0d got=%h exp=0", 31 - i, rt_data); end
    end
  endtask

  task automatic test_alu_write();
    int lat; logic [DW-1:0] crs; logic da;
    run_instr(6'b000000, 5'd5, 32'h1234, 5'd5, lat, crs, da);
    model_retire(6'b000000, 5'd5, 32'h1234);
    $display("txn alu op=00 rd=5 data=00001234 lat=%0d", lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL alu_latency got=%0d exp=5", lat); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL alu_done_width got=%b exp=0", da); end
    rs_addr = 5'd5; #1;
    n_checks++; if (rs_data !== 32'h1234) begin n_fail++; $display("FAIL alu_read r5 got=%h exp=00001234", rs_data); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL alu_instret got=%h exp=%h", instret, model_instret); end
  endtask

  task automatic test_sw_nowrite();
    int lat; logic [DW-1:0] crs; logic da;
    run_instr(6'b010000, 5'd7, 32'hFFFF, 5'd7, lat, crs, da);
    model_retire(6'b010000, 5'd7, 32'hFFFF);
    $display("txn sw op=10 rd=7 data=0000ffff lat=%0d", lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sw_latency got=%0d exp=5", lat); end
    n_checks++; if (crs !== 32'h0) begin n_fail++; $display("FAIL sw_commit_read got=%h exp=0", crs); end
    rt_addr = 5'd7; #1;
    n_checks++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL sw_r7 got=%h exp=0", rt_data); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL sw_instret got=%h exp=%h", instret, model_instret); end
  endtask

  task automatic test_lw_r0();
    int lat; logic [DW-1:0] crs; logic da;
    run_instr(6'b010001, 5'd0, 32'hDEAD, 5'd0, lat, crs, da);
    model_retire(6'b010001, 5'd0, 32'hDEAD);
    $display("txn lw op=11 rd=0 data=0000dead lat=%0d", lat);
    n_checks++; if (crs !== 32'h0) begin n_fail++; $display("FAIL r0_commit_read got=%h exp=0", crs); end
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_rs got=%h exp=0", rs_data); end
    n_checks++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL r0_rt got=%h exp=0", rt_data); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL r0_instret got=%h exp=%h", instret, model_instret); end
  endtask

  task automatic test_bypass();
    int lat; logic [DW-1:0] crs; logic da;
    run_instr(6'b000001, 5'd9, 32'hA5A5, 5'd9, lat, crs, da);
    model_retire(6'b000001, 5'd9, 32'hA5A5);
    $display("txn bypass op=01 rd=9 data=0000a5a5 commit_rs=%h", crs);
    n_checks++; if (crs !== 32'hA5A5) begin n_fail++; $display("FAIL bypass_commit got=%h exp=0000a5a5", crs); end
    rt_addr = 5'd9; #1;
    n_checks++; if (rt_data !== 32'hA5A5) begin n_fail++; $display("FAIL bypass_after got=%h exp=0000a5a5", rt_data); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] crs, exp_crs; logic da;
    logic [5:0] o; logic [4:0] r, p, q; logic [DW-1:0] d;
    logic [5:0] op_tab [8];
    op_tab = '{6'd0, 6'd3, 6'd5, 6'd16, 6'd17, 6'd32, 6'd33, 6'd6};
    for (int t = 0; t < 40; t++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 7)];
      r = 5'($urandom);
      d = DW'($urandom);
      p = ($urandom_range(0, 1) == 1) ? r : 5'($urandom);
      exp_crs = model_bypass(o, r, d, p);
      run_instr(o, r, d, p, lat, crs, da);
      model_retire(o, r, d);
      $display("txn rnd%0d op=%h rd=%0d data=%h probe=%0d lat=%0d", t, o, r, d, p, lat);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rnd_latency t=%0d got=%0d exp=5", t, lat); end
      n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL rnd_done_width t=%0d got=%b exp=0", t, da); end
      n_checks++; if (crs !== exp_crs) begin n_fail++; $display("FAIL rnd_commit t=%0d got=%h exp=%h", t, crs, exp_crs); end
      q = 5'($urandom);
      rs_addr = r; rt_addr = q; #1;
      n_checks++; if (rs_data !== model_read(r)) begin n_fail++; $display("FAIL rnd_rs t=%0d r%0d got=%h exp=%h", t, r, rs_data, model_read(r)); end
      n_checks++; if (rt_data !== model_read(q)) begin n_fail++; $display("FAIL rnd_rt t=%0d r%0d got=%h exp=%h", t, q, rt_data, model_read(q)); end
      n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL rnd_instret t=%0d got=%h exp=%h", t, instret, model_instret); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses; int lat; logic [DW-1:0] crs; logic da;
    @(negedge clk);
    op = 6'd2; rd = 5'd11; wb_data_i = 32'h0BAD_F00D;
    start[3] = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1 || n == 3) start[3] = 1'b0;
      if (n == 2) start[3] = 1'b1;
      if (wb_done) pulses++;
    end
    model_retire(6'd2, 5'd11, 32'h0BAD_F00D);
    model_perr = 1'b1;
    $display("txn back_to_back op=02 rd=11 pulses=%0d phase_err=%b", pulses, phase_err);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_retires got=%0d exp=1", pulses); end
    n_checks++; if (phase_err !== model_perr) begin n_fail++; $display("FAIL b2b_phase_err got=%b exp=%b", phase_err, model_perr); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL b2b_instret got=%h exp=%h", instret, model_instret); end
    rs_addr = 5'd11; #1;
    n_checks++; if (rs_data !== model_read(5'd11)) begin n_fail++; $display("FAIL b2b_r11 got=%h exp=%h", rs_data, model_read(5'd11)); end
    run_instr(6'd4, 5'd12, 32'h77, 5'd12, lat, crs, da);
    model_retire(6'd4, 5'd12, 32'h77);
    $display("txn sticky op=04 rd=12 data=00000077 lat=%0d", lat);
    n_checks++; if (phase_err !== 1'b1) begin n_fail++; $display("FAIL phase_err_sticky got=%b exp=1", phase_err); end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    op = 6'd0; rd = 5'd3; wb_data_i = 32'hBEEF; start[3] = 1'b1;
    seen = 0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start[3] = 1'b0;
      if (wb_done) seen++;
    end
    rst_n = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (wb_done) seen++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (wb_done) seen++;
    end
    $display("txn reset_abort op=00 rd=3 data=0000beef wb_done_seen=%0d", seen);
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_wb_done got=%0d exp=0", seen); end
    rs_addr = 5'd3; #1;
    n_checks++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL abort_r3 got=%h exp=0", rs_data); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL abort_instret got=%h exp=%h", instret, model_instret); end
    n_checks++; if (phase_err !== model_perr) begin n_fail++; $display("FAIL abort_phase_err got=%b exp=%b", phase_err, model_perr); end
  endtask

  task automatic test_startup_high();
    int seen;
    @(negedge clk);
    rst_n = 1'b0;
    start[3] = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (wb_done) seen++;
      if (n == 8) start[3] = 1'b0;
    end
    $display("txn startup_high wb_done_seen=%0d instret=%h", seen, instret);
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL startup_edge got=%0d exp=0", seen); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL startup_instret got=%h exp=%h", instret, model_instret); end
  endtask

  task automatic test_instret_wrap();
    int lat; logic [DW-1:0] crs; logic da;
    @(negedge clk);
    force dut.instret_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.instret_d;
    model_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL wrap_preload got=%h exp=%h", instret, model_instret); end
    run_instr(6'd16, 5'd4, 32'h1, 5'd4, lat, crs, da);
    model_retire(6'd16, 5'd4, 32'h1);
    $display("txn wrap op=10 rd=4 lat=%0d instret=%h", lat, instret);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_latency got=%0d exp=5", lat); end
    n_checks++; if (instret !== model_instret) begin n_fail++; $display("FAIL wrap_instret got=%h exp=%h", instret, model_instret); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_sw_nowrite();
    test_lw_r0();
    test_bypass();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_startup_high();
    test_instret_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
